// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Default digit count, slot length, dead time and anodo blank level.
package display_scanner_pkg;

    localparam int DIGITOS_DEF = 4;
    localparam int DIVISOR_DEF = 50000;
    localparam int APAGADO_DEF = 16;

    // Anodes are active-low: a set bit means that digit is dark.
    localparam logic ANODO_OFF = 1'b1;

endpackage

// File: rtl/divisor_varredura.sv
// Slot/digit prescaler: cont counts within a slot, idx selects the digit.
// fim_quadro flags the last cycle of the last slot (frame boundary).
module divisor_varredura
    import display_scanner_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int DIGITOS = DIGITOS_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [$clog2(DIVISOR)-1:0] cont,
    output logic [$clog2(DIGITOS)-1:0] idx,
    output logic                       fim_quadro
);

    localparam int CW = $clog2(DIVISOR);
    localparam int IW = $clog2(DIGITOS);

    logic [CW-1:0] cont_q, cont_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          fim_slot;
    logic          ultimo;

    assign fim_slot   = (cont_q == CW'(DIVISOR - 1));
    assign ultimo     = (idx_q == IW'(DIGITOS - 1));
    assign fim_quadro = fim_slot && ultimo;

    always_comb begin
        cont_d = cont_q + CW'(1);
        idx_d  = idx_q;
        if (fim_slot) begin
            cont_d = '0;
            idx_d  = ultimo ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
            idx_q  <= '0;
        end else begin
            cont_q <= cont_d;
            idx_q  <= idx_d;
        end
    end

    assign cont = cont_q;
    assign idx  = idx_q;

endmodule

// File: rtl/display_scanner.sv
// Double-buffered multiplexed hex display driver feeding displayDecoder.
// Optional LEADING_ZERO_BLANK_EN darkens digits above the top non-zero nibble.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIGITOS = DIGITOS_DEF,
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int APAGADO = APAGADO_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4*DIGITOS-1:0] valor,
    input  logic                 carregar,
    output logic                 pronto,
    output logic [3:0]           digito,
    output logic [DIGITOS-1:0]   anodo,
    output logic                 quadro
);

    localparam int CW = $clog2(DIVISOR);
    localparam int IW = $clog2(DIGITOS);
    localparam int W  = 4 * DIGITOS;

    logic [CW-1:0] cont;
    logic [IW-1:0] idx;
    logic          fim_quadro;

    logic [W-1:0]       sombra_q, sombra_d;
    logic [W-1:0]       display_q, display_d;
    logic               pendente_q, pendente_d;
    logic [DIGITOS-1:0] anodo_q, anodo_d;
    logic [3:0]         digito_q, digito_d;
    logic               quadro_q;
    logic [DIGITOS-1:0] mascara;
    logic               aceso;

    divisor_varredura #(
        .DIVISOR (DIVISOR),
        .DIGITOS (DIGITOS)
    ) u_div (
        .clock      (clock),
        .reset      (reset),
        .cont       (cont),
        .idx        (idx),
        .fim_quadro (fim_quadro)
    );

    // Load wins over sombra at the boundary so the newest value is shown.
    always_comb begin
        sombra_d   = sombra_q;
        display_d  = display_q;
        pendente_d = pendente_q;
        if (fim_quadro) begin
            if (carregar) begin
                display_d = valor;
            end else if (pendente_q) begin
                display_d = sombra_q;
            end
            pendente_d = 1'b0;
        end else if (carregar) begin
            sombra_d   = valor;
            pendente_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k stays lit when any nibble at or above k is non-zero.
    always_comb begin
        logic acc;
        acc        = 1'b0;
        mascara    = '0;
        mascara[0] = 1'b1;
        for (int k = DIGITOS - 1; k >= 1; k--) begin
            acc        = acc | (|display_q[4*k +: 4]);
            mascara[k] = acc;
        end
    end
`else
    assign mascara = '1;
`endif

    assign aceso = (cont < CW'(DIVISOR - APAGADO)) && mascara[idx];

    always_comb begin
        anodo_d = {DIGITOS{ANODO_OFF}};
        if (aceso) begin
            anodo_d[idx] = ~ANODO_OFF;
        end
        digito_d = display_q[{idx, 2'b00} +: 4];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sombra_q   <= '0;
            display_q  <= '0;
            pendente_q <= 1'b0;
            anodo_q    <= {DIGITOS{ANODO_OFF}};
            digito_q   <= '0;
            quadro_q   <= 1'b0;
        end else begin
            sombra_q   <= sombra_d;
            display_q  <= display_d;
            pendente_q <= pendente_d;
            anodo_q    <= anodo_d;
            digito_q   <= digito_d;
            quadro_q   <= fim_quadro;
        end
    end

    assign pronto = ~pendente_q;
    assign digito = digito_q;
    assign anodo  = anodo_q;
    assign quadro = quadro_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomised bench for display_scanner against a cycle-count reference model.
// Build with +define+LEADING_ZERO_BLANK_EN to check the blanking variant.
module tb_display_scanner;

    localparam int DG = 4;
    localparam int DV = 8;
    localparam int AP = 2;
    localparam int W  = 4 * DG;
    localparam int FR = DG * DV;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          carregar = 1'b0;
    logic [W-1:0]  valor = '0;
    logic          pronto;
    logic          quadro;
    logic [3:0]    digito;
    logic [DG-1:0] anodo;

    always #5 clock = ~clock;

    display_scanner #(
        .DIGITOS (DG),
        .DIVISOR (DV),
        .APAGADO (AP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .valor    (valor),
        .carregar (carregar),
        .pronto   (pronto),
        .digito   (digito),
        .anodo    (anodo),
        .quadro   (quadro)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: cycles since reset and the three value registers.
    int           c = 0;
    logic [W-1:0] m_disp = '0;
    logic [W-1:0] m_sombra = '0;
    bit           m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, c);
        end
    endtask

    function automatic int top_digit(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int k = 0; k < DG; k++)
            if (((v >> (4 * k)) & 'hF) != 0) r = k;
        return r;
    endfunction

    task automatic step();
        logic [DG-1:0] ea;
        logic [3:0]    ed;
        bit            eq;
        bit            lit;
        int            ct;
        int            ix;
        @(posedge clock);
        if (reset) begin
            c        = 0;
            m_disp   = '0;
            m_sombra = '0;
            m_pend   = 1'b0;
            ea       = '1;
            ed       = '0;
            eq       = 1'b0;
        end else begin
            ct  = c % DV;
            ix  = (c / DV) % DG;
            lit = ct < DV - AP;
`ifdef LEADING_ZERO_BLANK_EN
            if (ix > top_digit(m_disp)) lit = 1'b0;
`endif
            ea = lit ? ~(DG'(1) << ix) : '1;
            ed = 4'((m_disp >> (4 * ix)) & 'hF);
            eq = (c % FR) == FR - 1;
            if (eq) begin
                if (carregar) m_disp = valor;
                else if (m_pend) m_disp = m_sombra;
                m_pend = 1'b0;
            end else if (carregar) begin
                m_sombra = valor;
                m_pend   = 1'b1;
            end
            c++;
        end
        #1;
        check("anodo", 32'(anodo), 32'(ea));
        check("digito", 32'(digito), 32'(ed));
        check("quadro", 32'(quadro), 32'(eq));
        check("pronto", 32'(pronto), 32'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 2 * FR && (c % FR) != phase; i++) step();
    endtask

    task automatic load(input logic [W-1:0] v);
        valor    = v;
        carregar = 1'b1;
        step();
        carregar = 1'b0;
    endtask

    initial begin
        run(2);
        reset = 1'b0;
        run(70);

        align(10);
        load(16'hA3C5);
        check("pronto_pend", 32'(pronto), 32'd0);
        run(70);

        align(5);
        load(16'h1111);
        run(3);
        load(16'h2222);
        run(70);

        align(FR - 1);
        load(16'h00F0);
        check("pronto_bnd", 32'(pronto), 32'd1);
        run(40);

        align(2 * DV + 1);
        load(16'h5555);
        run(2);
        reset = 1'b1;
        step();
        check("anodo_rst", 32'(anodo), 32'hF);
        reset = 1'b0;
        run(40);

        load(16'h0070);
        run(70);
        load(16'h0000);
        run(70);

        for (int i = 0; i < 1500; i++) begin
            carregar = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                valor = W'($urandom_range(0, 255));
            else
                valor = W'($urandom);
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        carregar = 1'b0;
        reset    = 1'b0;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
